// File: rtl/fpu_fp64_to_fp32_pipe.sv
// Two-stage FP64 -> FP32 narrowing converter with valid/ready on both sides.
// S1 unpacks, classifies and rebiases; S2 rounds, packs and raises flags (flush-to-zero).
module fpu_fp64_to_fp32_pipe (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data,
   input  logic [1:0]  in_rmode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [3:0]  out_flags
);

   typedef enum logic [1:0] {
      RM_RNE = 2'd0,
      RM_RTZ = 2'd1,
      RM_RUP = 2'd2,
      RM_RDN = 2'd3
   } rmode_e;

   // TINY covers both denormal inputs and results below the FP32 normal range.
   typedef enum logic [2:0] {
      CLS_NORM,
      CLS_QNAN,
      CLS_SNAN,
      CLS_INF,
      CLS_ZERO,
      CLS_TINY,
      CLS_OFLOW
   } cls_e;

   typedef struct packed {
      logic        sign;
      cls_e        cls;
      rmode_e      rmode;
      logic [7:0]  exp;
      logic [22:0] man;
      logic        guard;
      logic        sticky;
   } s1_t;

   logic              w_s2_adv;
   logic              w_s1_adv;
   logic              w_in_fire;
   logic [10:0]       w_exp64;
   logic [51:0]       w_frac;
   logic signed [11:0] w_e32;
   s1_t               w_s1_next;

   logic              r_s1_valid;
   s1_t               r_s1;

   logic              w_inc;
   logic [23:0]       w_sum;
   logic [8:0]        w_exp_rnd;
   logic              w_inexact;
   logic              w_to_inf;
   logic [31:0]       w_ovf_res;
   logic [31:0]       w_res;
   logic [3:0]        w_flags;

   logic              r_out_valid;
   logic [31:0]       r_out_data;
   logic [3:0]        r_out_flags;

   // ---------------- flow control ----------------
   assign w_s2_adv  = !r_out_valid || out_ready;
   assign w_s1_adv  = r_s1_valid && w_s2_adv;
   assign in_ready  = !r_s1_valid || w_s2_adv;
   assign w_in_fire = in_valid && in_ready;

   // ---------------- stage 1: unpack / classify ----------------
   assign w_exp64 = in_data[62:52];
   assign w_frac  = in_data[51:0];
   assign w_e32   = $signed({1'b0, w_exp64}) - 12'sd896;

   // NOTE: every field gets a default before the priority chain, so no latch is inferred.
   always_comb begin
      w_s1_next.sign   = in_data[63];
      w_s1_next.cls    = CLS_NORM;
      w_s1_next.rmode  = rmode_e'(in_rmode);
      w_s1_next.exp    = w_e32[7:0];
      w_s1_next.man    = w_frac[51:29];
      w_s1_next.guard  = w_frac[28];
      w_s1_next.sticky = |w_frac[27:0];
      if (w_exp64 == 11'h7FF) begin
         if (w_frac != 52'd0) w_s1_next.cls = w_frac[51] ? CLS_QNAN : CLS_SNAN;
         else                 w_s1_next.cls = CLS_INF;
      end else if (w_exp64 == 11'h000) begin
         w_s1_next.cls = (w_frac == 52'd0) ? CLS_ZERO : CLS_TINY;
      end else if (w_e32 <= 12'sd0) begin
         w_s1_next.cls = CLS_TINY;
      end else if (w_e32 >= 12'sd255) begin
         w_s1_next.cls = CLS_OFLOW;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset)          r_s1_valid <= 1'b0;
      else if (w_in_fire) r_s1_valid <= 1'b1;
      else if (w_s1_adv)  r_s1_valid <= 1'b0;
   end

   // NOTE: the S1 payload carries no reset; r_s1_valid alone decides whether it means anything.
   always_ff @(posedge clk) begin
      if (w_in_fire) r_s1 <= w_s1_next;
   end

   // ---------------- stage 2: round / pack ----------------
   always_comb begin
      w_inc = 1'b0;
      unique case (r_s1.rmode)
         RM_RNE: w_inc = r_s1.guard && (r_s1.sticky || r_s1.man[0]);
         RM_RTZ: w_inc = 1'b0;
         RM_RUP: w_inc = !r_s1.sign && (r_s1.guard || r_s1.sticky);
         RM_RDN: w_inc = r_s1.sign && (r_s1.guard || r_s1.sticky);
      endcase
   end

   // A mantissa carry leaves w_sum[22:0] all zero, which is exactly the required m'.
   assign w_sum     = {1'b0, r_s1.man} + {23'd0, w_inc};
   assign w_exp_rnd = {1'b0, r_s1.exp} + {8'd0, w_sum[23]};
   assign w_inexact = r_s1.guard || r_s1.sticky;
   assign w_to_inf  = (r_s1.rmode == RM_RNE) ||
                      (r_s1.rmode == RM_RUP && !r_s1.sign) ||
                      (r_s1.rmode == RM_RDN &&  r_s1.sign);
   assign w_ovf_res = w_to_inf ? {r_s1.sign, 8'hFF, 23'h000000}
                               : {r_s1.sign, 8'hFE, 23'h7FFFFF};

   always_comb begin
      w_res   = {r_s1.sign, 31'd0};
      w_flags = 4'b0000;
      unique case (r_s1.cls)
         CLS_QNAN: w_res = 32'h7FC00000;
         CLS_SNAN: begin
            w_res   = 32'h7FC00000;
            w_flags = 4'b1000;
         end
         CLS_INF:  w_res = {r_s1.sign, 8'hFF, 23'h000000};
         CLS_ZERO: w_res = {r_s1.sign, 31'd0};
         CLS_TINY: begin
            w_res   = {r_s1.sign, 31'd0};
            w_flags = 4'b0011;
         end
         CLS_OFLOW: begin
            w_res   = w_ovf_res;
            w_flags = 4'b0101;
         end
         CLS_NORM: begin
            if (w_exp_rnd >= 9'd255) begin
               w_res   = w_ovf_res;
               w_flags = 4'b0101;
            end else begin
               w_res   = {r_s1.sign, w_exp_rnd[7:0], w_sum[22:0]};
               w_flags = {3'b000, w_inexact};
            end
         end
         default: begin
            w_res   = {r_s1.sign, 31'd0};
            w_flags = 4'b0000;
         end
      endcase
   end

   // Output register: holds steady while the consumer stalls.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= 32'd0;
         r_out_flags <= 4'd0;
      end else begin
         if (w_s2_adv) r_out_valid <= r_s1_valid;
         if (w_s1_adv) begin
            r_out_data  <= w_res;
            r_out_flags <= w_flags;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_flags = r_out_flags;

endmodule

// File: tb/tb_fpu_fp64_to_fp32_pipe.sv
// Self-checking bench for fpu_fp64_to_fp32_pipe: directed vectors, backpressure,
// mid-stream reset and a random stream scored against an arithmetic reference model.
module tb_fpu_fp64_to_fp32_pipe;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic [1:0]  in_rmode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_flags;

   int total = 0;
   int bad   = 0;
   logic [35:0] sb_q[$];

   fpu_fp64_to_fp32_pipe dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_rmode  (in_rmode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_flags (out_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: value-level rounding of the 53-bit significand to 24 bits.
   function automatic void ref_conv(input logic [63:0] x, input logic [1:0] rm,
                                    output logic [31:0] d, output logic [3:0] fl);
      logic s;
      int e;
      int be;
      logic [51:0] f;
      longint unsigned sig, q, rem;
      logic up, inex, to_inf;
      s  = x[63];
      e  = int'(x[62:52]);
      f  = x[51:0];
      fl = 4'b0000;
      d  = 32'h0;
      up = 1'b0;
      to_inf = (rm == 2'd0) || (rm == 2'd2 && !s) || (rm == 2'd3 && s);
      if (e == 2047) begin
         if (f != 52'd0) begin
            d     = 32'h7FC00000;
            fl[3] = !f[51];
         end else begin
            d = {s, 8'hFF, 23'h0};
         end
      end else if (e == 0) begin
         d  = {s, 31'h0};
         fl = (f != 52'd0) ? 4'b0011 : 4'b0000;
      end else begin
         be = e - 1023 + 127;
         if (be <= 0) begin
            d  = {s, 31'h0};
            fl = 4'b0011;
         end else begin
            sig  = {12'h001, f};
            q    = sig >> 29;
            rem  = sig - (q << 29);
            inex = (rem != 64'd0);
            case (rm)
               2'd0:    up = (rem > 64'd268435456) || (rem == 64'd268435456 && q[0]);
               2'd1:    up = 1'b0;
               2'd2:    up = !s && inex;
               default: up = s && inex;
            endcase
            q = q + 64'(up);
            if (q == 64'd16777216) begin
               q  = q >> 1;
               be = be + 1;
            end
            if (be >= 255) begin
               fl = 4'b0101;
               d  = to_inf ? {s, 8'hFF, 23'h0} : {s, 8'hFE, 23'h7FFFFF};
            end else begin
               d  = {s, be[7:0], q[22:0]};
               fl = {3'b000, inex};
            end
         end
      end
   endfunction

   function automatic logic [63:0] rand_operand();
      logic [63:0] r;
      logic [10:0] e;
      logic [51:0] f;
      r = {$urandom(), $urandom()};
      f = r[51:0];
      case ($urandom_range(0, 7))
         0: e = 11'h000;
         1: begin
            e = 11'h7FF;
            if ($urandom_range(0, 1) == 0) f = 52'h0;
         end
         2: e = 11'(870 + $urandom_range(0, 40));
         3: e = 11'(1135 + $urandom_range(0, 16));
         4: begin
            e = 11'(897 + $urandom_range(0, 253));
            f[51:29] = 23'h7FFFFF;
         end
         default: e = 11'(897 + $urandom_range(0, 253));
      endcase
      if ($urandom_range(0, 2) == 0) f[27:0] = 28'h0;
      return {r[63], e, f};
   endfunction

   task automatic push_exp(input logic [63:0] x, input logic [1:0] rm);
      logic [31:0] d;
      logic [3:0]  fl;
      ref_conv(x, rm, d, fl);
      sb_q.push_back({d, fl});
   endtask

   task automatic out_compare(input string tag);
      logic [35:0] e;
      check({tag, "/sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check({tag, "/data"},  out_data,  e[35:4]);
         check({tag, "/flags"}, out_flags, e[3:0]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Inputs are already driven at the negedge; observe handshakes, then advance.
   task automatic tick(input string tag);
      #1;
      if (out_valid && out_ready) out_compare(tag);
      if (in_valid && in_ready) push_exp(in_data, in_rmode);
      step();
   endtask

   task automatic directed(input string tag, input logic [63:0] x, input logic [1:0] rm,
                           input logic [31:0] ed, input logic [3:0] ef);
      in_valid  = 1'b1;
      in_data   = x;
      in_rmode  = rm;
      out_ready = 1'b1;
      #1;
      check({tag, "/in_ready"}, in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      in_data  = {$urandom(), $urandom()};
      in_rmode = 2'($urandom());
      #1;
      check({tag, "/lat1"}, out_valid, 1'b0);
      step();
      #1;
      check({tag, "/lat2"},  out_valid, 1'b1);
      check({tag, "/data"},  out_data,  ed);
      check({tag, "/flags"}, out_flags, ef);
      step();
   endtask

   initial begin
      logic [63:0] bp[4];
      logic [1:0]  bp_rm[4];
      logic [31:0] held_d;
      logic [3:0]  held_f;
      int idx, emitted, first_c, last_c;

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = 64'h0;
      in_rmode  = 2'd0;
      out_ready = 1'b0;
      held_d    = 32'h0;
      held_f    = 4'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst/out_valid", out_valid, 1'b0);
      check("rst/out_data",  out_data,  32'h0);
      check("rst/out_flags", out_flags, 4'h0);
      check("rst/in_ready",  in_ready,  1'b1);
      reset = 1'b0;
      step();

      directed("one_rne",      64'h3FF0000000000000, 2'd0, 32'h3F800000, 4'b0000);
      directed("tie_rne",      64'h3FF0000010000000, 2'd0, 32'h3F800000, 4'b0001);
      directed("tie_rup",      64'h3FF0000010000000, 2'd2, 32'h3F800001, 4'b0001);
      directed("tie_rtz",      64'h3FF0000010000000, 2'd1, 32'h3F800000, 4'b0001);
      directed("tie_odd_rne",  64'h3FF0000030000000, 2'd0, 32'h3F800002, 4'b0001);
      directed("neg_tie_rdn",  64'hBFF0000010000000, 2'd3, 32'hBF800001, 4'b0001);
      directed("ovf_rne",      64'h47F0000000000000, 2'd0, 32'h7F800000, 4'b0101);
      directed("ovf_rtz",      64'h47F0000000000000, 2'd1, 32'h7F7FFFFF, 4'b0101);
      directed("ovf_neg_rup",  64'hC7F0000000000000, 2'd2, 32'hFF7FFFFF, 4'b0101);
      directed("carry_ovf",    64'h47EFFFFFF0000000, 2'd0, 32'h7F800000, 4'b0101);
      directed("uflow",        64'h3800000000000000, 2'd0, 32'h00000000, 4'b0011);
      directed("denorm_in",    64'h0000000000000001, 2'd0, 32'h00000000, 4'b0011);
      directed("neg_zero",     64'h8000000000000000, 2'd0, 32'h80000000, 4'b0000);
      directed("snan",         64'h7FF0000000000001, 2'd0, 32'h7FC00000, 4'b1000);
      directed("qnan_neg",     64'hFFF8000000000000, 2'd0, 32'h7FC00000, 4'b0000);
      directed("neg_inf",      64'hFFF0000000000000, 2'd0, 32'hFF800000, 4'b0000);

      // Backpressure: four back-to-back offers against a stalled consumer.
      for (int i = 0; i < 4; i++) begin
         bp[i]    = {1'($urandom()), 11'(897 + $urandom_range(0, 253)), 20'($urandom()), $urandom()};
         bp_rm[i] = 2'($urandom());
      end
      idx       = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         in_valid = 1'b1;
         in_data  = bp[idx];
         in_rmode = bp_rm[idx];
         #1;
         if (c == 2) begin
            check("bp/out_valid", out_valid, 1'b1);
            held_d = out_data;
            held_f = out_flags;
         end
         if (c >= 2) check("bp/in_ready_low", in_ready, 1'b0);
         if (c == 3) begin
            check("bp/hold_data",  out_data,  held_d);
            check("bp/hold_flags", out_flags, held_f);
         end
         if (in_valid && in_ready) begin
            push_exp(in_data, in_rmode);
            idx++;
         end
         step();
      end
      check("bp/accepted", idx, 2);
      out_ready = 1'b1;
      emitted   = 0;
      first_c   = -1;
      last_c    = -1;
      for (int c = 0; c < 12; c++) begin
         in_valid = (idx < 4);
         if (idx < 4) begin
            in_data  = bp[idx];
            in_rmode = bp_rm[idx];
         end
         #1;
         if (out_valid && out_ready) begin
            out_compare("bp_out");
            if (first_c < 0) first_c = c;
            last_c = c;
            emitted++;
         end
         if (in_valid && in_ready) begin
            push_exp(in_data, in_rmode);
            idx++;
         end
         step();
      end
      in_valid = 1'b0;
      check("bp/emitted",      emitted, 4);
      check("bp/back_to_back", last_c - first_c, 3);
      check("bp/sb_empty",     sb_q.size(), 0);

      // Reset with both stages full and a handshake offered on each side.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'h3FF0000000000000;
      in_rmode  = 2'd0;
      step();
      in_data = 64'h4000000000000000;
      step();
      #1;
      check("rst_mid/pre_full", out_valid, 1'b1);
      reset     = 1'b1;
      out_ready = 1'b1;
      in_data   = 64'h4008000000000000;
      step();
      #1;
      check("rst_mid/out_valid", out_valid, 1'b0);
      check("rst_mid/out_data",  out_data,  32'h0);
      check("rst_mid/out_flags", out_flags, 4'h0);
      check("rst_mid/in_ready",  in_ready,  1'b1);
      reset    = 1'b0;
      in_valid = 1'b0;
      sb_q.delete();
      for (int c = 0; c < 5; c++) begin
         #1;
         check("rst_mid/no_stale", out_valid, 1'b0);
         step();
      end

      // Random stream with random stalls on both sides.
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_data   = rand_operand();
         in_rmode  = 2'($urandom());
         out_ready = ($urandom_range(0, 9) < 7);
         tick("rand");
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 10 && sb_q.size() != 0; i++) tick("drain");
      check("drain/sb_empty", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
